// File: rtl/lead_zero_denorm_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : lead_zero_denorm_seq_if
//  Description : Handshake and data bundle for lead_zero_denorm_seq.
//                Input side:  in_valid_i / in_ready_o with operand M and
//                             leading-zero count C.
//                Output side: out_valid_o / out_ready_i with the
//                             denormalized word, the one-hot first-'1'
//                             vector and, optionally, the sticky bit.
//  Modports    : master - upstream/downstream environment
//                slave  - the denormalizer itself
//  Macro       : LZDN_STICKY_EN adds out_sticky_o to the bundle
//  Revision    : 1.0 - initial release
// ============================================================================
interface lead_zero_denorm_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_m_i;
    logic [CNTW-1:0]  in_cnt_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_a_o;
    logic [WIDTH-1:0] out_z_o;
`ifdef LZDN_STICKY_EN
    logic             out_sticky_o;
`endif

    modport master (
        output in_valid_i,
        output in_m_i,
        output in_cnt_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_a_o,
        input  out_z_o
`ifdef LZDN_STICKY_EN
        ,
        input  out_sticky_o
`endif
    );

    modport slave (
        input  in_valid_i,
        input  in_m_i,
        input  in_cnt_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_a_o,
        output out_z_o
`ifdef LZDN_STICKY_EN
        ,
        output out_sticky_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/lead_zero_denorm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lead_zero_denorm_seq
//  Description : Iterative denormalizer, the inverse of the leading-zero
//                detect/encode path. Rebuilds A = M >> C (zero fill) with a
//                radix-2 barrel shifter that consumes one count bit per
//                clock, and emits the one-hot "first '1' from MSB" vector
//                decoded from C.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous reset, active-high
//                bus    - lead_zero_denorm_seq_if.slave
//                         in_valid_i/in_ready_o, in_m_i, in_cnt_i,
//                         out_valid_o/out_ready_i, out_a_o, out_z_o,
//                         out_sticky_o (LZDN_STICKY_EN only)
//  Macro       : LZDN_STICKY_EN - adds the sticky (OR of shifted-out bits)
//                output and its logic
//  Revision    : 1.0 - initial release
// ============================================================================
module lead_zero_denorm_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    lead_zero_denorm_seq_if.slave bus
);

    // Stage counter runs 0..CNTW: values 0..CNTW-1 are shift stages, the
    // value CNTW is the result-load slot that gives the constant latency of
    // CNTW+1 edges from acceptance to out_valid_o.
    localparam int STGW = $clog2(CNTW + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [STGW-1:0]  stage_q,  stage_d;
    logic [WIDTH-1:0] work_q,   work_d;     // working (shifting) register
    logic [CNTW-1:0]  cnt_q,    cnt_d;      // captured count
    logic [WIDTH-1:0] zdec_q,   zdec_d;     // one-hot decode taken at capture
    logic [WIDTH-1:0] res_a_q,  res_a_d;    // presented result
    logic [WIDTH-1:0] res_z_q,  res_z_d;    // presented one-hot
`ifdef LZDN_STICKY_EN
    logic             stk_q,    stk_d;      // running sticky during SHIFT
    logic             res_s_q,  res_s_d;    // presented sticky
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_accept;
    logic             w_last_stage;
    logic [WIDTH-1:0] w_zdec;
    logic [WIDTH-1:0] w_step;
`ifdef LZDN_STICKY_EN
    logic             w_lost;

    // Bits [n-1:0] set; used to pick the bits a right shift by n discards.
    function automatic logic [WIDTH-1:0] low_mask(input int n);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction
`endif

    assign w_accept     = (state_q == c_IDLE) && bus.in_valid_i;
    assign w_last_stage = (stage_q == STGW'(CNTW));

    // One-hot decode of C: bit (WIDTH-1-C) when C < WIDTH, otherwise zero.
    // Depends on the count only, never on M.
    always_comb begin
        w_zdec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_zdec[i] = (int'(bus.in_cnt_i) == (WIDTH - 1 - i));
        end
    end

    // One barrel stage: stage k shifts by 2**k when C[k] is set. A stage
    // whose distance reaches the word width clears the register outright.
    always_comb begin
        w_step = work_q;
`ifdef LZDN_STICKY_EN
        w_lost = 1'b0;
`endif
        for (int k = 0; k < CNTW; k++) begin
            if ((stage_q == STGW'(k)) && cnt_q[k]) begin
                if ((k >= 31) || ((1 << k) >= WIDTH)) begin
                    w_step = '0;
`ifdef LZDN_STICKY_EN
                    w_lost = |work_q;
`endif
                end else begin
                    w_step = work_q >> (1 << k);
`ifdef LZDN_STICKY_EN
                    w_lost = |(work_q & low_mask(1 << k));
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (bus.in_valid_i) begin
                    state_d = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_last_stage) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.in_ready_o  = (state_q == c_IDLE);
        bus.out_valid_o = (state_q == c_DONE);
    end

    // Result registers are separate from the working register so the
    // presented values stay put after the handshake and through the next
    // transaction's SHIFT phase, changing only when the next DONE arrives.
    assign bus.out_a_o = res_a_q;
    assign bus.out_z_o = res_z_q;
`ifdef LZDN_STICKY_EN
    assign bus.out_sticky_o = res_s_q;
`endif

    // ------------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        stage_d = stage_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zdec_d  = zdec_q;
        res_a_d = res_a_q;
        res_z_d = res_z_q;
`ifdef LZDN_STICKY_EN
        stk_d   = stk_q;
        res_s_d = res_s_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    stage_d = '0;
                    work_d  = bus.in_m_i;
                    cnt_d   = bus.in_cnt_i;
                    zdec_d  = w_zdec;
`ifdef LZDN_STICKY_EN
                    stk_d   = 1'b0;
`endif
                end
            end
            c_SHIFT: begin
                if (w_last_stage) begin
                    // All count bits consumed: publish the result.
                    stage_d = '0;
                    res_a_d = work_q;
                    res_z_d = zdec_q;
`ifdef LZDN_STICKY_EN
                    res_s_d = stk_q;
`endif
                end else begin
                    stage_d = stage_q + STGW'(1);
                    work_d  = w_step;
`ifdef LZDN_STICKY_EN
                    stk_d   = stk_q | w_lost;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            zdec_q  <= '0;
            res_a_q <= '0;
            res_z_q <= '0;
`ifdef LZDN_STICKY_EN
            stk_q   <= 1'b0;
            res_s_q <= 1'b0;
`endif
        end else begin
            stage_q <= stage_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zdec_q  <= zdec_d;
            res_a_q <= res_a_d;
            res_z_q <= res_z_d;
`ifdef LZDN_STICKY_EN
            stk_q   <= stk_d;
            res_s_q <= res_s_d;
`endif
        end
    end

endmodule
`default_nettype wire
